if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 219 +++++++++++++++++++++
 tb/tb_if_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage.
//
// Issues at most one instruction-memory request at a time. The returned word
// is presented to decode together with its own pc and the link value pc+4.
// A one-entry skid register catches a response that arrives while the output
// slot is full and not being consumed. A redirect (jmp_en) takes priority
// over every other event in the same cycle. A response already in flight
// when the redirect arrives is marked for discard, so stale code never
// reaches decode.
//
// Handshakes:
//   imem: a transfer happens on an edge where imem_req && imem_gnt. The
//         response comes back later as a single imem_rvalid pulse.
//   decode: the payload is handed over on an edge where if_valid && id_ready.
//           While if_valid && !id_ready the payload holds steady.
//   Neither handshake is blocked by stall. Stall only suppresses new requests.
module if_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jmp_en,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc_cur,
  output logic [XLEN-1:0] if_pc_next,
  input  logic            id_ready,
  output logic            flush_out,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0] ALIGN_MSK = ~{{(XLEN-2){1'b0}}, 2'b11};

  logic [1:0]      state;
  logic [1:0]      state_nxt;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_req;
  logic            discard;

  logic            skid_valid;
  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_pc;

  logic            slot_valid;
  logic [31:0]     slot_inst;
  logic [XLEN-1:0] slot_pc;
  logic [XLEN-1:0] slot_pc_next;
  logic            flush_q;

  // Per-cycle decisions decoded from the state.
  logic            grant;
  logic            consume;
  logic            resp_take;
  logic            slot_load_resp;
  logic            skid_load;
  logic            skid_drain;
  logic [XLEN-1:0] jmp_aligned;

  // Redirect target, always word aligned.
  assign jmp_aligned = jmp_target & ALIGN_MSK;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A redirect steers every state, and where a request is
  // still in flight it leaves RESP waiting on that response with discard set.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        if (grant) begin
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_RESP: begin
        if (imem_rvalid) begin
          if (skid_load) begin
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_REQ;
          end
        end else begin
          state_nxt = S_RESP;
        end
      end
      S_HOLD: begin
        if (jmp_en || consume) begin
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM outputs and per-cycle decisions.
  always_comb begin
    imem_req       = (state == S_REQ) && !stall;
    grant          = imem_req && imem_gnt;
    consume        = slot_valid && id_ready;
    resp_take      = (state == S_RESP) && imem_rvalid && !jmp_en && !discard;
    slot_load_resp = resp_take && (!slot_valid || id_ready);
    skid_load      = resp_take && slot_valid && !id_ready;
    skid_drain     = (state == S_HOLD) && skid_valid && consume && !jmp_en;
  end

  // Fetch pointer, the address of the request in flight, and the discard mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      pc_req  <= '0;
      discard <= 1'b0;
    end else begin
      if (grant) begin
        pc_req <= pc;
      end
      if (jmp_en) begin
        pc      <= jmp_aligned;
        discard <= (grant) || ((state == S_RESP) && !imem_rvalid);
      end else begin
        if (grant) begin
          pc <= pc + PC_STEP;
        end
        if ((state == S_RESP) && imem_rvalid) begin
          discard <= 1'b0;
        end
      end
    end
  end

  // Skid register: fills when the slot is blocked, empties into the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else if (jmp_en) begin
      skid_valid <= 1'b0;
    end else if (skid_load) begin
      skid_valid <= 1'b1;
      skid_inst  <= imem_rdata;
      skid_pc    <= pc_req;
    end else if (skid_drain) begin
      skid_valid <= 1'b0;
    end
  end

  // Output slot: loads from a fresh response or from the skid. It empties
  // once consumed, and a redirect empties it regardless of id_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid   <= 1'b0;
      slot_inst    <= '0;
      slot_pc      <= '0;
      slot_pc_next <= '0;
    end else if (jmp_en) begin
      slot_valid <= 1'b0;
    end else if (slot_load_resp) begin
      slot_valid   <= 1'b1;
      slot_inst    <= imem_rdata;
      slot_pc      <= pc_req;
      slot_pc_next <= pc_req + PC_STEP;
    end else if (skid_drain) begin
      slot_valid   <= 1'b1;
      slot_inst    <= skid_inst;
      slot_pc      <= skid_pc;
      slot_pc_next <= skid_pc + PC_STEP;
    end else if (consume) begin
      slot_valid <= 1'b0;
    end
  end

  // Flush pulse: high for the single cycle after a redirect edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= jmp_en;
    end
  end

  assign imem_addr  = pc;
  assign if_valid   = slot_valid;
  assign if_inst    = slot_inst;
  assign if_pc_cur  = slot_pc;
  assign if_pc_next = slot_pc_next;
  assign flush_out  = flush_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a cycle-by-cycle vector table plus a reset
// sequence, with an in-order scoreboard on the decode handshake.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        jmp_en;
  logic [31:0] jmp_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc_cur;
  logic [31:0] if_pc_next;
  logic        id_ready;
  logic        flush_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        jmp;
    logic [31:0] tgt;
    logic        stl;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_flush;
  } vec_t;

  vec_t vt[$];

  localparam logic [31:0] A0 = 32'h0000_0013;
  localparam logic [31:0] A1 = 32'h0010_0093;
  localparam logic [31:0] A2 = 32'h0020_0113;
  localparam logic [31:0] B0 = 32'h1111_1111;
  localparam logic [31:0] C0 = 32'h2222_2222;
  localparam logic [31:0] D0 = 32'h3333_3333;
  localparam logic [31:0] E0 = 32'h4444_4444;
  localparam logic [31:0] C1 = 32'h7777_7777;
  localparam logic [31:0] F0 = 32'h6666_6666;
  localparam logic [31:0] ST = 32'hDEAD_BEEF;

  if_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc_cur  (if_pc_cur),
    .if_pc_next (if_pc_next),
    .id_ready   (id_ready),
    .flush_out  (flush_out),
    .dbg_state  (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic jmp, input logic [31:0] tgt,
                              input logic stl, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_inst,
                              input logic [31:0] e_pc, input logic e_flush);
    vec_t v;
    v.jmp = jmp; v.tgt = tgt; v.stl = stl; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_vld = e_vld; v.e_inst = e_inst; v.e_pc = e_pc; v.e_flush = e_flush;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver.
  task automatic drive(input vec_t v);
    jmp_en      = v.jmp;
    jmp_target  = v.tgt;
    stall       = v.stl;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    id_ready    = v.rdy;
  endtask

  // Scoreboard: every decode handshake must deliver the next expected word.
  task automatic sb_check(input string tag);
    if (if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s sb_extra: got %h expected none", tag, if_inst);
      end else begin
        chk({tag, " sb_inst"}, if_inst, exp_q.pop_front());
      end
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, v.e_req});
    chk({tag, " imem_addr"}, imem_addr, v.e_addr);
    chk({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, v.e_vld});
    chk({tag, " flush_out"}, {31'd0, flush_out}, {31'd0, v.e_flush});
    if (v.e_vld) begin
      chk({tag, " if_inst"}, if_inst, v.e_inst);
      chk({tag, " if_pc_cur"}, if_pc_cur, v.e_pc);
      chk({tag, " if_pc_next"}, if_pc_next, v.e_pc + 32'd4);
    end
    sb_check(tag);
  endtask

  // Drive at the falling edge, check just after, then step to the next one.
  task automatic run_vec(input string tag, input vec_t v);
    drive(v);
    #1;
    check_out(tag, v);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, " imem_addr"}, imem_addr, 32'd0);
    chk({tag, " if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, " if_inst"}, if_inst, 32'd0);
    chk({tag, " if_pc_cur"}, if_pc_cur, 32'd0);
    chk({tag, " if_pc_next"}, if_pc_next, 32'd0);
    chk({tag, " flush_out"}, {31'd0, flush_out}, 32'd0);
    chk({tag, " state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Words expected across the decode handshake, in order.
    exp_q.push_back(A0);
    exp_q.push_back(A1);
    exp_q.push_back(A2);
    exp_q.push_back(D0);
    exp_q.push_back(F0);

    // jmp tgt stl gnt rv rdata rdy | req addr vld inst pc flush
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  0, 32'h0,        0, 0,  0,            0)); // c0 IDLE
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  1, 32'h0,        0, 0,  0,            0)); // c1 req 0
    vt.push_back(mk(0, 0,            0, 0, 1, A0, 1,  0, 32'h4,        0, 0,  0,            0)); // c2 resp
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  1, 32'h4,        1, A0, 32'h0,        0)); // c3 req 4
    vt.push_back(mk(0, 0,            0, 0, 1, A1, 1,  0, 32'h8,        0, 0,  0,            0)); // c4
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  0,  1, 32'h8,        1, A1, 32'h4,        0)); // c5 req 8
    vt.push_back(mk(0, 0,            0, 0, 1, A2, 0,  0, 32'hC,        1, A1, 32'h4,        0)); // c6 -> HOLD
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  0,  0, 32'hC,        1, A1, 32'h4,        0)); // c7 HOLD
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  0, 32'hC,        1, A1, 32'h4,        0)); // c8 drain
    vt.push_back(mk(0, 0,            0, 0, 0, 0,  0,  1, 32'hC,        1, A2, 32'h8,        0)); // c9
    vt.push_back(mk(0, 0,            1, 1, 0, 0,  1,  0, 32'hC,        1, A2, 32'h8,        0)); // c10 stall
    vt.push_back(mk(0, 0,            1, 1, 0, 0,  1,  0, 32'hC,        0, 0,  0,            0)); // c11 stall
    vt.push_back(mk(0, 0,            1, 1, 0, 0,  1,  0, 32'hC,        0, 0,  0,            0)); // c12 stall
    vt.push_back(mk(0, 0,            0, 0, 0, 0,  1,  1, 32'hC,        0, 0,  0,            0)); // c13
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  1, 32'hC,        0, 0,  0,            0)); // c14 grant
    vt.push_back(mk(1, 32'h102,      0, 0, 0, 0,  1,  0, 32'h10,       0, 0,  0,            0)); // c15 jmp RESP
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  0, 32'h100,      0, 0,  0,            1)); // c16
    vt.push_back(mk(0, 0,            0, 1, 1, ST, 1,  0, 32'h100,      0, 0,  0,            0)); // c17 stale
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  1, 32'h100,      0, 0,  0,            0)); // c18
    vt.push_back(mk(0, 0,            0, 0, 1, B0, 1,  0, 32'h104,      0, 0,  0,            0)); // c19
    vt.push_back(mk(1, 32'h20,       0, 0, 0, 0,  0,  1, 32'h104,      1, B0, 32'h100,      0)); // c20 jmp REQ
    vt.push_back(mk(1, 32'h100,      0, 1, 0, 0,  1,  1, 32'h20,       0, 0,  0,            1)); // c21 jmp+gnt
    vt.push_back(mk(0, 0,            0, 1, 1, ST, 1,  0, 32'h100,      0, 0,  0,            1)); // c22 stale
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  1, 32'h100,      0, 0,  0,            0)); // c23
    vt.push_back(mk(0, 0,            0, 0, 1, C0, 0,  0, 32'h104,      0, 0,  0,            0)); // c24
    vt.push_back(mk(1, 32'hFFFF_FFFC,0, 0, 0, 0,  0,  1, 32'h104,      1, C0, 32'h100,      0)); // c25
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  1, 32'hFFFF_FFFC,0, 0,  0,            1)); // c26 wrap
    vt.push_back(mk(0, 0,            0, 0, 1, D0, 1,  0, 32'h0,        0, 0,  0,            0)); // c27
    vt.push_back(mk(0, 0,            0, 1, 0, 0,  1,  1, 32'h0,        1, D0, 32'hFFFF_FFFC,0)); // c28
    vt.push_back(mk(1, 32'h203,      0, 0, 1, E0, 1,  0, 32'h4,        0, 0,  0,            0)); // c29 jmp+rv
    vt.push_back(mk(0, 0,            0, 0, 0, 0,  1,  1, 32'h200,      0, 0,  0,            1)); // c30
    vt.push_back(mk(0, 0,            0, 0, 0, 0,  1,  1, 32'h200,      0, 0,  0,            0)); // c31

    // Reset values while reset is held.
    #1;
    check_reset("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      run_vec($sformatf("v%0d", i), vt[i]);
    end

    // Fill the slot, launch another request, then reset in the middle of RESP.
    run_vec("h0", mk(0, 0, 0, 1, 0, 0,  0, 1, 32'h200, 0, 0,  0,       0));
    run_vec("h1", mk(0, 0, 0, 0, 1, C1, 0, 0, 32'h204, 0, 0,  0,       0));
    run_vec("h2", mk(0, 0, 0, 1, 0, 0,  0, 1, 32'h204, 1, C1, 32'h200, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    // A late response after reset must be ignored in IDLE and REQ.
    run_vec("r0", mk(0, 0, 0, 0, 1, ST, 1, 0, 32'h0, 0, 0,  0,    0));
    run_vec("r1", mk(0, 0, 0, 0, 1, ST, 1, 1, 32'h0, 0, 0,  0,    0));
    run_vec("r2", mk(0, 0, 0, 1, 0, 0,  1, 1, 32'h0, 0, 0,  0,    0));
    run_vec("r3", mk(0, 0, 0, 0, 1, F0, 1, 0, 32'h4, 0, 0,  0,    0));
    run_vec("r4", mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h4, 1, F0, 32'h0, 0));
    run_vec("r5", mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h4, 0, 0,  0,    0));

    chk("sb_left", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
